multicycle_ctrl_fsm: RTL

Sequencing controller for the multi-cycle variant of the RV32I core. It steps the shared datapath through fetch, decode, execute, memory and writeback, and handles request/ready handshakes to instruction and data memory. It issues per-state write enables to the PC, IR and register file. ALU operation selection stays in the combinational decoder; this block owns only sequencing.

---
 rtl/multicycle_ctrl_fsm.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I sequencing controller: fetch/decode/exec/mem/wb with memory timeout trap.
// Optional macro SYSTEM_NOP_EN makes MISC_MEM and SYSTEM legal 3-cycle NOPs.
module multicycle_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       stall,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic       reg_we,
  output logic       instr_retired,
  output logic       trap,
  output logic       timeout_err,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [TO_W-1:0] WAIT_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_t          cur;
  logic [6:0]      op_q;
  logic [TO_W-1:0] wait_cnt;

  function automatic logic is_nop(input logic [6:0] op);
`ifdef SYSTEM_NOP_EN
    return (op == OPC_MISC_MEM) || (op == OPC_SYSTEM);
`else
    return 1'b0 & (op == OPC_MISC_MEM || op == OPC_SYSTEM);
`endif
  endfunction

  function automatic logic is_legal(input logic [6:0] op);
    logic ok;
    case (op)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
      OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: ok = 1'b1;
      default:                                 ok = is_nop(op);
    endcase
    return ok;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur         <= S_IDLE;
      op_q        <= 7'd0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (cur)
        S_IDLE: begin
          wait_cnt <= '0;
          cur      <= S_FETCH;
        end
        // FETCH and MEM share the handshake: ready wins over the timeout threshold.
        S_FETCH, S_MEM: begin
          if (mem_ready) begin
            wait_cnt <= '0;
            if (cur == S_FETCH)
              cur <= S_DECODE;
            else if (op_q == OPC_STORE)
              cur <= S_FETCH;
            else
              cur <= S_WB;
          end else if (wait_cnt == WAIT_LAST) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b1;
            cur         <= S_TRAP;
          end else begin
            wait_cnt <= wait_cnt + TO_W'(1);
          end
        end
        S_DECODE: begin
          if (!stall) begin
            op_q <= opcode;
            cur  <= is_legal(opcode) ? S_EXEC : S_TRAP;
          end
        end
        S_EXEC: begin
          if (!stall) begin
            if (op_q == OPC_LOAD || op_q == OPC_STORE)
              cur <= S_MEM;
            else if (op_q == OPC_BRANCH || is_nop(op_q))
              cur <= S_FETCH;
            else
              cur <= S_WB;
          end
        end
        S_WB: begin
          if (!stall)
            cur <= S_FETCH;
        end
        S_TRAP: cur <= S_TRAP;
        default: cur <= S_TRAP;
      endcase
    end
  end

  // Enables are decoded from the state register plus same-cycle ready/stall,
  // so reset (state forced to IDLE) drops them all immediately.
  logic exec_retire;
  logic mem_retire;

  always_comb begin
    exec_retire = (cur == S_EXEC) && !stall && ((op_q == OPC_BRANCH) || is_nop(op_q));
    mem_retire  = (cur == S_MEM) && mem_ready && (op_q == OPC_STORE);

    imem_req      = (cur == S_FETCH);
    ir_we         = (cur == S_FETCH) && mem_ready;
    dmem_req      = (cur == S_MEM);
    dmem_we       = (cur == S_MEM) && (op_q == OPC_STORE);
    reg_we        = (cur == S_WB) && !stall;
    pc_we         = exec_retire || mem_retire || reg_we;
    instr_retired = exec_retire || mem_retire || reg_we;
    trap          = (cur == S_TRAP);
    state         = cur;
  end

endmodule
